mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port (valid/ready request, response pulse) between instruction fetch (IF, read-only) and execute/load-store (LS, read or write).
- Registered FSM sequencer with round-robin grant, operand latching at grant, per-transaction timeout and error return.
- Sits between the IFU/LSU and the AXI4-lite read/write bridges.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; wmask width is DATA_W/8
- TIMEOUT, 255, cycles in ADDR+WAIT before error completion; 0 disables timeout

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-low
if_req  in  1  IF read request, level, held until if_done
if_addr  in  ADDR_W  IF read address
if_done  out  1  one-cycle completion pulse to IF
if_err  out  1  valid with if_done; 1 = timeout
if_rdata  out  DATA_W  IF read data, valid with if_done, held after
ls_req  in  1  LS request, level, held until ls_done
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  LS write data
ls_wmask  in  DATA_W/8  LS byte enables
ls_done  out  1  one-cycle completion pulse to LS
ls_err  out  1  valid with ls_done; 1 = timeout
ls_rdata  out  DATA_W  LS read data, valid with ls_done on reads, held after
mem_valid  out  1  downstream request valid
mem_we  out  1  downstream write enable
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_wmask  out  DATA_W/8  downstream byte enables
mem_ready  in  1  downstream accepts request
mem_resp  in  1  downstream response pulse
mem_rdata  in  DATA_W  downstream read data, valid with mem_resp
busy  out  1  high in any state except IDLE
grant_ls  out  1  current or last owner: 0 = IF, 1 = LS

Behaviour:
- Reset (RST low at a clock edge): state IDLE, all outputs 0, timeout counter 0, last owner = LS (so IF wins the first tie). Any in-flight transaction is abandoned; a late mem_resp is ignored.
- All outputs are registered.
- States and transitions:
  - IDLE: sample if_req/ls_req.
    - If neither is set, stay.
    - If one is set, grant it.
    - If both are set, grant the one that was not the last owner.
    - On grant: latch addr, we, wdata, wmask (IF: we=0, wmask=0); set grant_ls; go to ADDR.
  - ADDR: mem_valid=1 with latched fields, stable until accepted. On mem_ready go to WAIT and drop mem_valid next cycle.
  - WAIT: on mem_resp, capture mem_rdata and go to RESP. mem_resp is honored only in WAIT; downstream must not respond in the ready cycle.
  - RESP: pulse the granted port's done for exactly one cycle.
    - err=0 normally.
    - Read: rdata updated. Write: ls_rdata unchanged.
    - Update last owner. Go to IDLE. Request inputs are ignored in RESP.
- Latency: req seen in IDLE at cycle 0, then mem_valid at cycle 1. With mem_ready at cycle 1 and mem_resp at cycle 2, done is at cycle 3 (minimum 3 cycles).
- Back-to-back: a requester keeping req high after done is re-arbitrated in the following IDLE cycle. With both requesting continuously, ownership strictly alternates.
- Operand changes after grant are ignored. A req deasserted mid-transaction does not abort it; done still pulses to the owner.
- Timeout (TIMEOUT>0):
  - Counter clears on grant and increments each cycle in ADDR or WAIT.
  - When it reaches TIMEOUT, go to RESP with err=1 and owner's rdata=0 (reads), and drop mem_valid.
  - A mem_resp in the same cycle as expiry wins (err=0).
- Non-owner done/err stay 0 at all times. if_done and ls_done are never high together.

Test Plan:
- Reset, then if_req=1, if_addr=0x8000_0000; mem_ready same cycle as mem_valid; mem_resp next cycle with rdata=0x1122_3344_5566_7788 -> mem_valid at cycle 1, if_done at cycle 3, if_rdata=0x1122334455667788, if_err=0, busy low after.
- if_req and ls_req held together from reset, both kept high for 4 completions -> grant order IF, LS, IF, LS; exactly one done per transaction; grant_ls=0,1,0,1.
- LS write ls_addr=0x8000_0100, wdata=0xDEAD_BEEF, wmask=0x0F; mem_ready delayed 3 cycles -> mem_valid held 4 cycles with stable fields, mem_we=1; ls_done pulses; ls_rdata unchanged.
- TIMEOUT=8, LS read with no mem_ready -> ls_done with ls_err=1 and ls_rdata=0, 8 cycles after entering ADDR; mem_valid low afterwards; a later stray mem_resp is ignored.
- RST low for one edge while in WAIT, then mem_resp -> all outputs 0, state IDLE, no done pulse; next if_req+ls_req tie grants IF.
- if_addr changed and if_req dropped one cycle after grant -> mem_addr keeps the original address; if_done still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch (read-only) and load/store.
// Round-robin grant, operands latched at grant, per-transaction timeout with error completion.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_done,
    output logic                if_err,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_done,
    output logic                ls_err,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_ready,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                grant_ls
);
    // state | meaning
    // IDLE  | arbitrate between IF and LS
    // ADDR  | request presented downstream, waiting for mem_ready
    // WAIT  | request accepted, waiting for mem_resp
    // RESP  | done/err pulse to the owner, then back to IDLE
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state;
    logic             last_ls;
    logic [CNT_W-1:0] cnt;
    logic             pick_ls;
    logic             expire;
    logic             fin_ok;
    logic             fin_to;

    assign pick_ls = ls_req && (!if_req || !last_ls);
    assign expire  = (TIMEOUT > 0) && (cnt == CNT_LAST);

    // A response arriving in the expiry cycle wins over the timeout; so does an
    // acceptance, so no request is left outstanding downstream.
    always_comb begin
        fin_ok = 1'b0;
        fin_to = 1'b0;
        if (state == WAIT && mem_resp)
            fin_ok = 1'b1;
        else if ((state == ADDR && !mem_ready) || (state == WAIT && !mem_resp))
            fin_to = expire;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            last_ls   <= 1'b1;
            cnt       <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            busy      <= 1'b0;
            grant_ls  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || ls_req) begin
                        grant_ls  <= pick_ls;
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        mem_we    <= pick_ls && ls_we;
                        mem_addr  <= pick_ls ? ls_addr : if_addr;
                        mem_wdata <= pick_ls ? ls_wdata : '0;
                        mem_wmask <= pick_ls ? ls_wmask : '0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                end
                RESP: begin
                    if_done <= 1'b0;
                    if_err  <= 1'b0;
                    ls_done <= 1'b0;
                    ls_err  <= 1'b0;
                    busy    <= 1'b0;
                    last_ls <= grant_ls;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (fin_ok || fin_to) begin
                state     <= RESP;
                mem_valid <= 1'b0;
                if (grant_ls) begin
                    ls_done <= 1'b1;
                    ls_err  <= fin_to;
                    if (!mem_we)
                        ls_rdata <= fin_to ? '0 : mem_rdata;
                end else begin
                    if_done  <= 1'b1;
                    if_err   <= fin_to;
                    if_rdata <= fin_to ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule
